// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1x3 router: walks each packet through
// header decode, payload load, full stall and parity, and drives the strobes.
module router_fsm #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_in,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              fifo_empty_0,
  input  logic              fifo_empty_1,
  input  logic              fifo_empty_2,
  input  logic              soft_rst_0,
  input  logic              soft_rst_1,
  input  logic              soft_rst_2,
  input  logic              parity_done,
  input  logic              low_pkt_valid,
  output logic              detect_add,
  output logic              write_en_reg,
  output logic              lfd_state,
  output logic              ld_state,
  output logic              laf_state,
  output logic              full_state,
  output logic              rst_int_reg,
  output logic              busy,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  localparam logic [ADDR_W-1:0] RSVD_ADDR = ADDR_W'(3);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hdr_ok;
  logic              live_empty;
  logic              sel_empty;
  logic              sel_srst;

  // Flag muxes: live header address for the decode decision, latched address afterwards.
  always_comb begin
    live_empty = 1'b0;
    case (data_in)
      ADDR_W'(0): live_empty = fifo_empty_0;
      ADDR_W'(1): live_empty = fifo_empty_1;
      ADDR_W'(2): live_empty = fifo_empty_2;
      default:    live_empty = 1'b0;
    endcase
    sel_empty = 1'b0;
    sel_srst  = 1'b0;
    case (addr_q)
      ADDR_W'(0): begin sel_empty = fifo_empty_0; sel_srst = soft_rst_0; end
      ADDR_W'(1): begin sel_empty = fifo_empty_1; sel_srst = soft_rst_1; end
      ADDR_W'(2): begin sel_empty = fifo_empty_2; sel_srst = soft_rst_2; end
      default:    begin sel_empty = 1'b0;         sel_srst = 1'b0;       end
    endcase
  end

  assign hdr_ok = pkt_valid && (data_in != RSVD_ADDR);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (hdr_ok) begin
          addr_d  = data_in;
          state_d = live_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        if (sel_empty) state_d = LOAD_FIRST_DATA;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A timeout on the FIFO being served abandons the packet outright.
    if ((state_q != DECODE_ADDRESS) && sel_srst) state_d = DECODE_ADDRESS;
  end

  // Outputs are registered from the next state so they track the current state without glitches.
  always_ff @(posedge clk or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= DECODE_ADDRESS;
      addr_q       <= '0;
      detect_add   <= 1'b1;
      write_en_reg <= 1'b0;
      lfd_state    <= 1'b0;
      ld_state     <= 1'b0;
      laf_state    <= 1'b0;
      full_state   <= 1'b0;
      rst_int_reg  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      detect_add   <= (state_d == DECODE_ADDRESS);
      write_en_reg <= (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                      (state_d == LOAD_AFTER_FULL);
      lfd_state    <= (state_d == LOAD_FIRST_DATA);
      ld_state     <= (state_d == LOAD_DATA);
      laf_state    <= (state_d == LOAD_AFTER_FULL);
      full_state   <= (state_d == FIFO_FULL_STATE);
      rst_int_reg  <= (state_d == CHECK_PARITY_ERROR);
      busy         <= (state_d != DECODE_ADDRESS) && (state_d != LOAD_DATA);
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Randomized packet scenarios for router_fsm; each scenario is expanded into
// per-edge stimulus plus the phase the controller must show after that edge.
module tb_router_fsm;
  localparam int W = 8;
  localparam int P_D = 0, P_LFD = 1, P_LD = 2, P_FULL = 3;
  localparam int P_LAF = 4, P_LP = 5, P_CP = 6, P_WAIT = 7;

  typedef struct packed {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] srst;
    logic       pdone;
    logic       lowpv;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_rst_0, soft_rst_1, soft_rst_2;
  logic       detect_add, write_en_reg, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy;
  logic [2:0] dbg_state;
  logic [W-1:0] dut_out;

  stim_t        stim_q[$];
  logic [W-1:0] exp_q[$];
  int vectors = 0, miscompares = 0, applied = 0, checked = 0;

  router_fsm #(.ADDR_W(2)) dut (
    .clk(clk), .reset_in(reset_in), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1),
    .soft_rst_2(soft_rst_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .write_en_reg(write_en_reg), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .busy(busy), .dbg_state_o(dbg_state)
  );

  assign dut_out = {detect_add, write_en_reg, lfd_state, ld_state,
                    laf_state, full_state, rst_int_reg, busy};

  // clock / reset
  always #5 clk = ~clk;

  // {detect_add, write_en_reg, lfd, ld, laf, full, rst_int_reg, busy} per phase
  function automatic logic [W-1:0] out_of(input int p);
    case (p)
      P_D:     return 8'b1000_0000;
      P_LFD:   return 8'b0010_0001;
      P_LD:    return 8'b0101_0000;
      P_FULL:  return 8'b0000_0101;
      P_LAF:   return 8'b0100_1001;
      P_LP:    return 8'b0100_0001;
      P_CP:    return 8'b0000_0011;
      default: return 8'b0000_0001;
    endcase
  endfunction

  // Background stimulus: everything random except the served FIFO's soft reset.
  function automatic stim_t bg(input int a);
    stim_t s;
    s.pv    = 1'($urandom_range(0, 1));
    s.din   = 2'($urandom_range(0, 3));
    s.full  = 1'($urandom_range(0, 1));
    s.emp   = 3'($urandom);
    s.srst  = 3'($urandom);
    s.srst[a] = 1'b0;
    s.pdone = 1'($urandom_range(0, 1));
    s.lowpv = 1'($urandom_range(0, 1));
    return s;
  endfunction

  task automatic emit(input stim_t s, input int p);
    stim_q.push_back(s);
    exp_q.push_back(out_of(p));
  endtask

  task automatic check_out(input string name, input logic [W-1:0] exp);
    vectors++;
    if (dut_out !== exp) begin
      miscompares++;
      $display("FAIL %s #%0d: got %b required %b (state %0d) t=%0t",
               name, vectors, dut_out, exp, dbg_state, $time);
    end
  endtask

  task automatic full_stall(input int a);
    stim_t s;
    int f = $urandom_range(1, 3);
    repeat (f) begin s = bg(a); s.full = 1'b1; emit(s, P_FULL); end
    s = bg(a); s.full = 1'b0; emit(s, P_LAF);
  endtask

  // Scenario-level packet: idle, header, optional wait, payload, stalls, parity.
  task automatic gen_packet();
    stim_t s;
    int a = $urandom_range(0, 2);
    int w = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 4);
    int n = $urandom_range(1, 4);
    int ev, c;
    bit done = 0;
    repeat ($urandom_range(0, 2)) begin
      s = bg(a); s.srst = 3'($urandom);
      if ($urandom_range(0, 1) == 1) begin s.pv = 1'b1; s.din = 2'd3; end
      else s.pv = 1'b0;
      emit(s, P_D);
    end
    s = bg(a); s.pv = 1'b1; s.din = 2'(a); s.emp[a] = (w == 0);
    emit(s, (w == 0) ? P_LFD : P_WAIT);
    if (w > 0) begin
      repeat (w - 1) begin s = bg(a); s.emp[a] = 1'b0; emit(s, P_WAIT); end
      if ($urandom_range(0, 3) == 0) begin
        s = bg(a); s.srst[a] = 1'b1; s.pv = 1'b0; emit(s, P_D);
        return;
      end
      s = bg(a); s.emp[a] = 1'b1; emit(s, P_LFD);
    end
    s = bg(a); emit(s, P_LD);
    while (!done) begin
      repeat (n - 1) begin s = bg(a); s.pv = 1'b1; s.full = 1'b0; emit(s, P_LD); end
      ev = $urandom_range(0, 3);
      if (ev == 0) begin
        s = bg(a); s.pv = 1'b0; s.full = 1'b0; emit(s, P_LP);
        s = bg(a); emit(s, P_CP);
        if ($urandom_range(0, 1) == 1) begin
          full_stall(a);
          s = bg(a); s.pdone = 1'b1; s.pv = 1'b0; emit(s, P_D);
        end else begin
          s = bg(a); s.full = 1'b0; s.pv = 1'b0; emit(s, P_D);
        end
        done = 1;
      end else if (ev == 3) begin
        s = bg(a); s.srst[a] = 1'b1; s.pv = 1'b0; emit(s, P_D);
        done = 1;
      end else begin
        s = bg(a); s.full = 1'b1; emit(s, P_FULL);
        full_stall(a);
        c = $urandom_range(0, 2);
        s = bg(a);
        if (c == 0) begin
          s.pdone = 1'b1; s.pv = 1'b0; emit(s, P_D); done = 1;
        end else if (c == 1) begin
          s.pdone = 1'b0; s.lowpv = 1'b1; emit(s, P_LP);
          s = bg(a); emit(s, P_CP);
          s = bg(a); s.full = 1'b0; s.pv = 1'b0; emit(s, P_D); done = 1;
        end else begin
          s.pdone = 1'b0; s.lowpv = 1'b0; emit(s, P_LD);
          n = $urandom_range(1, 3);
        end
      end
    end
  endtask

  // driver: one queued vector per cycle; the last one is held when the queue runs dry
  task automatic drive_loop();
    stim_t s;
    forever begin
      @(negedge clk);
      if (stim_q.size() != 0) begin
        s = stim_q.pop_front();
        pkt_valid = s.pv; data_in = s.din; fifo_full = s.full;
        {fifo_empty_2, fifo_empty_1, fifo_empty_0} = s.emp;
        {soft_rst_2, soft_rst_1, soft_rst_0} = s.srst;
        parity_done = s.pdone; low_pkt_valid = s.lowpv;
        applied++;
      end
    end
  endtask

  // monitor: after every edge that consumed a vector, pop and compare
  task automatic monitor_loop();
    forever begin
      @(posedge clk);
      #1;
      if (applied > checked) begin
        checked++;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL scoreboard_underflow: got empty queue required an entry");
        end else check_out("edge", exp_q.pop_front());
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((stim_q.size() != 0 || applied != checked) && guard < 20000) begin
      @(posedge clk); guard++;
    end
    #2;
    if (guard >= 20000) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d pending required 0", stim_q.size());
    end
  endtask

  initial begin
    stim_t s;
    int a;
    reset_in = 1'b1;
    pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
    soft_rst_0 = 1'b0; soft_rst_1 = 1'b0; soft_rst_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
    fork
      drive_loop();
      monitor_loop();
    join_none
    #3;
    check_out("reset_state", out_of(P_D));
    @(negedge clk); @(negedge clk);
    reset_in = 1'b0;

    for (int p = 0; p < 60; p++) gen_packet();
    drain();

    // Park the controller in LOAD_DATA, then reset it between clock edges.
    a = $urandom_range(0, 2);
    s = bg(a); s.pv = 1'b1; s.din = 2'(a); s.emp[a] = 1'b1; emit(s, P_LFD);
    s = bg(a); emit(s, P_LD);
    s = bg(a); s.pv = 1'b1; s.full = 1'b0; emit(s, P_LD);
    drain();
    check_out("parked_in_load_data", out_of(P_LD));
    @(negedge clk); #2;
    reset_in = 1'b1;
    #1;
    check_out("async_reset", out_of(P_D));
    repeat (3) begin s = bg(a); s.pv = 1'b0; emit(s, P_D); end
    @(posedge clk); @(negedge clk); #2;
    reset_in = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
